fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 123 ++++++++++++
 tb/tb_fetch_queue.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetch requests under a credit limit,
// buffers returned words with their PCs, and flushes/refetches on redirect.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [63:0] inst_pc,
    input  logic        inst_ready
);

    // state | meaning
    // IDLE  | single cycle after reset release, no requests
    // FETCH | issuing requests and buffering responses
    // FLUSH | dropping responses for requests made before a redirect

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t        state;
    logic [63:0]   fetch_pc;
    logic [63:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   data_mem [DEPTH];
    logic [63:0]   pc_mem   [DEPTH];

    logic          redirect;
    logic          req_fire;
    logic          enq;
    logic          deq;
    logic          drop;
    logic          resp_owed;
    logic [CW:0]   credit_used;
    logic [CW-1:0] discard_redirect;

    // In-flight requests reserve a buffer slot, so a response always has room.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = (state == FETCH) && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc;

    assign redirect  = redirect_valid && (state != IDLE);
    assign req_fire  = imem_req_valid && imem_req_ready;
    assign enq       = imem_resp_valid && !redirect && (discard == '0) && (outstanding != '0);
    assign drop      = imem_resp_valid && !redirect && (discard != '0);
    assign deq       = inst_valid && inst_ready && !redirect;
    assign resp_owed = imem_resp_valid && ((outstanding != '0) || (discard != '0));

    assign discard_redirect = outstanding + discard - CW'(resp_owed);

    assign inst_valid = (count != '0);
    assign inst_data  = data_mem[head];
    assign inst_pc    = pc_mem[head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                default: begin
                    if (redirect) begin
                        count       <= '0;
                        head        <= '0;
                        tail        <= '0;
                        fetch_pc    <= redirect_pc;
                        resp_pc     <= redirect_pc;
                        outstanding <= '0;
                        discard     <= discard_redirect;
                        state       <= (discard_redirect != '0) ? FLUSH : FETCH;
                    end else begin
                        if (req_fire)
                            fetch_pc <= fetch_pc + 64'd4;
                        if (enq) begin
                            tail    <= tail + PW'(1);
                            resp_pc <= resp_pc + 64'd4;
                        end
                        if (deq)
                            head <= head + PW'(1);
                        outstanding <= outstanding + CW'(req_fire) - CW'(enq);
                        count       <= count + CW'(enq) - CW'(deq);
                        if (drop) begin
                            discard <= discard - CW'(1);
                            if (discard == CW'(1))
                                state <= FETCH;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            data_mem[tail] <= imem_resp_data;
            pc_mem[tail]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory model with configurable latency, scoreboard
// monitor on the decode side, directed scenarios and a randomized redirect soak.
module tb_fetch_queue;

    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        inst_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] exp_q[$];
    bit          seq_mode = 1'b0;
    logic [63:0] seq_next = 64'h0;
    int          delivered = 0;

    bit          mem_rand = 1'b0;
    bit          mem_ready_fixed = 1'b1;
    int          mem_lat = 1;
    int          cyc = 0;
    int          last_due = 0;
    logic [63:0] pend_addr[$];
    int          pend_due[$];

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [63:0] pc);
        return ~pc[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory: in-order responses, latency >= 1, cleared by reset.
    always @(negedge clk) begin
        int lat;
        int due;
        if (reset) begin
            pend_addr.delete();
            pend_due.delete();
            imem_resp_valid = 1'b0;
            imem_req_ready  = mem_ready_fixed;
        end else begin
            cyc++;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = word_of(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
            end
            imem_req_ready = mem_rand ? 1'($urandom_range(0, 1)) : mem_ready_fixed;
            #2;
            if (!reset && imem_req_valid && imem_req_ready) begin
                lat = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(due);
            end
        end
    end

    // Scoreboard monitor on the decode handshake.
    always @(negedge clk) begin
        logic [63:0] e;
        #3;
        if (!reset && inst_valid && inst_ready && !redirect_valid) begin
            delivered++;
            if (seq_mode) begin
                check("seq_pc", inst_pc, seq_next);
                check("seq_data", inst_data, word_of(seq_next));
                seq_next = inst_pc + 64'd4;
            end else if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_inst: got pc %h expected none", inst_pc);
            end else begin
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e);
                check("inst_data", inst_data, word_of(e));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic push_seq(input logic [63:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 64'(4 * i));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (exp_q.size() != 0 && n < budget);
        inst_ready = 1'b0;
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fires;
        int n;
        bit found;
        bit prev_redir;
        int to_redir;

        // Reset values before any clock edge
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_req_addr", imem_req_addr, RST_PC);

        // Streaming, one instruction per cycle
        do_reset();
        inst_ready = 1'b1;
        push_seq(64'h0, 8);
        #4 check("idle_no_req", imem_req_valid, 0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            #4;
            check("stream_req_valid", imem_req_valid, 1);
            check("stream_req_addr", imem_req_addr, 64'(4 * (k - 1)));
            if (k >= 3) check("stream_inst_valid", inst_valid, 1);
        end
        drain(20);

        // Decode stall: credit limit stops requests at DEPTH
        do_reset();
        fires = 0;
        repeat (20) begin
            #4 if (imem_req_valid && imem_req_ready) fires++;
            @(negedge clk);
        end
        #4;
        check("stall_fires", 64'(fires), 64'(DEPTH));
        check("stall_count", 64'(dut.count), 64'(DEPTH));
        check("stall_req_valid", imem_req_valid, 0);
        check("stall_inst_valid", inst_valid, 1);
        check("stall_fetch_addr", imem_req_addr, 64'h10);
        @(negedge clk);
        inst_ready = 1'b1;
        push_seq(64'h0, 12);
        drain(40);

        // Redirect with two responses in flight, latency 3
        mem_lat = 3;
        do_reset();
        inst_ready = 1'b1;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        #4 check("redir_req_blocked", imem_req_valid, 0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #4;
        check("flush_state", 64'(dut.state), 64'd2);
        check("flush_discard", 64'(dut.discard), 64'd2);
        check("flush_no_req", imem_req_valid, 0);
        check("flush_inst_valid", inst_valid, 0);
        @(negedge clk);
        #4 check("flush_state_2", 64'(dut.state), 64'd2);
        @(negedge clk);
        #4;
        check("refetch_state", 64'(dut.state), 64'd1);
        check("refetch_req_valid", imem_req_valid, 1);
        check("refetch_addr", imem_req_addr, 64'h100);
        push_seq(64'h100, 8);
        drain(40);

        // Redirect colliding with a response and a dequeue, latency 2
        mem_lat = 2;
        do_reset();
        inst_ready = 1'b1;
        repeat (4) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        #4;
        check("collide_inst_valid", inst_valid, 1);
        check("collide_resp_valid", imem_resp_valid, 1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #4;
        check("collide_after_valid", inst_valid, 0);
        check("collide_count", 64'(dut.count), 64'd0);
        check("collide_discard", 64'(dut.discard), 64'd1);
        check("collide_state", 64'(dut.state), 64'd2);
        push_seq(64'h200, 8);
        @(negedge clk);
        #4;
        check("collide_refetch_state", 64'(dut.state), 64'd1);
        check("collide_refetch_addr", imem_req_addr, 64'h200);
        drain(40);
        mem_lat = 1;

        // Asynchronous reset with three buffered entries
        do_reset();
        fires = 0;
        repeat (5) begin
            #4 if (imem_req_valid && imem_req_ready) fires++;
            if (fires == 3) mem_ready_fixed = 1'b0;
            @(negedge clk);
        end
        #4;
        check("prereset_count", 64'(dut.count), 64'd3);
        check("prereset_inst_valid", inst_valid, 1);
        check("prereset_req_valid", imem_req_valid, 1);
        #3;
        reset = 1'b1;
        #1;
        check("async_inst_valid", inst_valid, 0);
        check("async_req_valid", imem_req_valid, 0);
        check("async_req_addr", imem_req_addr, RST_PC);
        @(negedge clk);
        @(negedge clk);
        mem_ready_fixed = 1'b1;
        reset = 1'b0;
        n = 0;
        found = 1'b0;
        while (!found && n < 10) begin
            #4;
            if (imem_req_valid && imem_req_ready) begin
                found = 1'b1;
                check("post_reset_first_addr", imem_req_addr, RST_PC);
                check("post_reset_idle_cycles", 64'(n), 64'd1);
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL post_reset_request: got none expected request within 10 cycles");
        end

        // Random soak with periodic redirects
        do_reset();
        mem_rand   = 1'b1;
        seq_mode   = 1'b1;
        seq_next   = RST_PC;
        delivered  = 0;
        prev_redir = 1'b0;
        to_redir   = 50;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            inst_ready = ($urandom_range(0, 3) != 0);
            to_redir--;
            if (to_redir <= 0 && !prev_redir) begin
                redirect_valid = 1'b1;
                if ($urandom_range(0, 7) == 0)
                    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0;
                else
                    redirect_pc = {$urandom(), $urandom()} & ~64'h3;
                seq_next = redirect_pc;
                to_redir = $urandom_range(20, 120);
            end
            #4;
            if (prev_redir) check("inst_valid_after_redirect", inst_valid, 0);
            if (redirect_valid) check("req_blocked_on_redirect", imem_req_valid, 0);
            if ((i % 64) == 0) check("no_overflow", 64'(dut.count <= DEPTH), 64'd1);
            prev_redir = redirect_valid;
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        repeat (30) @(negedge clk);
        check("random_progress", 64'(delivered > 1000), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
